tabuleiro_pecas: RTL and testbench

Board-storage and conflict-check responder for the piece-placement FSM. It accepts one placement request per `valida` pulse and expands the piece into board cells. It checks bounds, overlap with already-stored cells and the per-player fleet quota, then either writes the cells into that player's 8x8 occupancy map or answers `conflito`. A registered read port serves the attack/game phase.

---
 rtl/batalha_pkg.sv | 36 +++
 rtl/calcula_celula.sv | 38 +++
 rtl/tabuleiro_pecas.sv | 188 ++++++++++++++++++
 tb/tb_tabuleiro_pecas.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batalha_pkg.sv
// Shared definitions for the piece-placement board: piece types, lengths,
// default fleet quotas and the board FSM state encoding.
package batalha_pkg;

  typedef enum logic [2:0] {
    TIPO_NENHUM  = 3'd0,
    SUBMARINO    = 3'd1,
    CRUZADOR     = 3'd2,
    HIDROAVIAO   = 3'd3,
    ENCOURACADO  = 3'd4,
    PORTA_AVIOES = 3'd5
  } tipo_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } estado_e;

  localparam int N_SUB_DEF = 5;
  localparam int N_CRU_DEF = 2;
  localparam int N_HID_DEF = 2;
  localparam int N_ENC_DEF = 1;
  localparam int N_PA_DEF  = 1;

  function automatic logic tipo_valido(input logic [2:0] tipo);
    return (tipo >= SUBMARINO) && (tipo <= PORTA_AVIOES);
  endfunction

  // Piece length equals its type code; invalid codes have length 0.
  function automatic logic [2:0] comprimento(input logic [2:0] tipo);
    return tipo_valido(tipo) ? tipo : 3'd0;
  endfunction

endpackage

// File: rtl/calcula_celula.sv
// Combinational expansion of a latched piece into the board coordinates of
// cell k, plus an out-of-board flag.
module calcula_celula
  import batalha_pkg::*;
(
  input  logic [2:0] tipo,
  input  logic       direcao,
  input  logic       orientacao,
  input  logic [2:0] x1,
  input  logic [2:0] y1,
  input  logic [2:0] k,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       fora
);

  logic [3:0] base_main;
  logic [3:0] base_cross;
  logic [3:0] main_c;
  logic [3:0] cross_c;
  logic [3:0] x_c;
  logic [3:0] y_c;

  // 4-bit two's complement: every reachable result outside 0..7 has bit 3 set.
  always_comb begin
    base_main  = direcao ? {1'b0, y1} : {1'b0, x1};
    base_cross = direcao ? {1'b0, x1} : {1'b0, y1};
    main_c     = orientacao ? (base_main - {1'b0, k}) : (base_main + {1'b0, k});
    cross_c    = base_cross + {3'b000, (tipo == HIDROAVIAO) && (k == 3'd1)};
    x_c        = direcao ? cross_c : main_c;
    y_c        = direcao ? main_c : cross_c;
  end

  assign x    = x_c[2:0];
  assign y    = y_c[2:0];
  assign fora = x_c[3] | y_c[3];

endmodule

// File: rtl/tabuleiro_pecas.sv
// Board storage and conflict checker: validates one placement per request,
// writes it cell by cell into the player's 8x8 map, and serves a read port.
module tabuleiro_pecas
  import batalha_pkg::*;
#(
  parameter int N_SUB = N_SUB_DEF,
  parameter int N_CRU = N_CRU_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int N_ENC = N_ENC_DEF,
  parameter int N_PA  = N_PA_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valida,
  input  logic [2:0] tipo,
  input  logic       jogador,
  input  logic [2:0] X1,
  input  logic [2:0] Y1,
  input  logic       direcao,
  input  logic       orientacao,
  output logic       ready,
  output logic       conflito,
  output logic       fim,
  output logic [1:0] completo,
  input  logic       rdJogador,
  input  logic [2:0] rdX,
  input  logic [2:0] rdY,
  output logic       ocupado
);

  function automatic logic [2:0] cota(input logic [2:0] t);
    case (t)
      SUBMARINO:    cota = 3'(N_SUB);
      CRUZADOR:     cota = 3'(N_CRU);
      HIDROAVIAO:   cota = 3'(N_HID);
      ENCOURACADO:  cota = 3'(N_ENC);
      PORTA_AVIOES: cota = 3'(N_PA);
      default:      cota = 3'd0;
    endcase
  endfunction

  estado_e    estado_q, estado_d;
  logic [2:0] tipo_q, tipo_d;
  logic       jog_q, jog_d;
  logic [2:0] x1_q, x1_d;
  logic [2:0] y1_q, y1_d;
  logic       dir_q, dir_d;
  logic       ori_q, ori_d;
  logic [2:0] k_q, k_d;
  logic       conflito_q, conflito_d;
  logic       ocupado_q;
  logic [63:0] mapa_q [2];
  logic [63:0] mapa_d [2];
  logic [2:0]  cont_q [2][5];
  logic [2:0]  cont_d [2][5];

  logic [2:0] cel_x, cel_y;
  logic       cel_fora;
  logic [5:0] cel_idx;
  logic [2:0] tidx;
  logic       ultima;
  logic       cota_cheia;
  logic [1:0] completo_c;

  calcula_celula u_celula (
    .tipo       (tipo_q),
    .direcao    (dir_q),
    .orientacao (ori_q),
    .x1         (x1_q),
    .y1         (y1_q),
    .k          (k_q),
    .x          (cel_x),
    .y          (cel_y),
    .fora       (cel_fora)
  );

  assign cel_idx    = {cel_y, cel_x};
  assign tidx       = tipo_valido(tipo_q) ? (tipo_q - 3'd1) : 3'd0;
  assign ultima     = (k_q == (comprimento(tipo_q) - 3'd1));
  assign cota_cheia = (cont_q[jog_q][tidx] >= cota(tipo_q));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    estado_d   = estado_q;
    tipo_d     = tipo_q;
    jog_d      = jog_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    dir_d      = dir_q;
    ori_d      = ori_q;
    k_d        = k_q;
    conflito_d = conflito_q;
    mapa_d     = mapa_q;
    cont_d     = cont_q;

    case (estado_q)
      IDLE: begin
        if (valida) begin
          tipo_d   = tipo;
          jog_d    = jogador;
          x1_d     = X1;
          y1_d     = Y1;
          dir_d    = direcao;
          ori_d    = orientacao;
          k_d      = 3'd0;
          estado_d = CHECK;
        end
      end
      CHECK: begin
        if ((k_q == 3'd0) && (!tipo_valido(tipo_q) || cota_cheia)) begin
          conflito_d = 1'b1;
          estado_d   = RESP;
        end else if (cel_fora || mapa_q[jog_q][cel_idx]) begin
          conflito_d = 1'b1;
          estado_d   = RESP;
        end else if (ultima) begin
          k_d      = 3'd0;
          estado_d = WRITE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      WRITE: begin
        mapa_d[jog_q][cel_idx] = 1'b1;
        if (ultima) begin
          cont_d[jog_q][tidx] = cont_q[jog_q][tidx] + 3'd1;
          conflito_d          = 1'b0;
          estado_d            = RESP;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      RESP:    estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  always_comb begin
    completo_c = 2'b11;
    for (int p = 0; p < 2; p++) begin
      for (int t = 0; t < 5; t++) begin
        if (cont_q[p][t] != cota(3'(t + 1))) completo_c[p] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q   <= IDLE;
      tipo_q     <= 3'd0;
      jog_q      <= 1'b0;
      x1_q       <= 3'd0;
      y1_q       <= 3'd0;
      dir_q      <= 1'b0;
      ori_q      <= 1'b0;
      k_q        <= 3'd0;
      conflito_q <= 1'b0;
      ocupado_q  <= 1'b0;
      // NOTE: the maps are real state that must read empty after reset, so they are flops with reset, not RAM.
      mapa_q[0]  <= '0;
      mapa_q[1]  <= '0;
      for (int p = 0; p < 2; p++) begin
        for (int t = 0; t < 5; t++) cont_q[p][t] <= 3'd0;
      end
    end else begin
      estado_q   <= estado_d;
      tipo_q     <= tipo_d;
      jog_q      <= jog_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      dir_q      <= dir_d;
      ori_q      <= ori_d;
      k_q        <= k_d;
      conflito_q <= conflito_d;
      ocupado_q  <= mapa_q[rdJogador][{rdY, rdX}];
      mapa_q     <= mapa_d;
      cont_q     <= cont_d;
    end
  end

  assign ready    = (estado_q == IDLE);
  assign fim      = (estado_q == RESP);
  assign conflito = conflito_q;
  assign completo = completo_c;
  assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_tabuleiro_pecas.sv
// Self-checking bench for tabuleiro_pecas: directed scenarios plus random
// placements against a cell-list reference model of the board rules.
module tb_tabuleiro_pecas;

  logic       clk = 1'b0;
  logic       reset;
  logic       valida;
  logic [2:0] tipo;
  logic       jogador;
  logic [2:0] X1, Y1;
  logic       direcao, orientacao;
  logic       ready, conflito, fim;
  logic [1:0] completo;
  logic       rdJogador;
  logic [2:0] rdX, rdY;
  logic       ocupado;

  int n_cmp = 0;
  int n_err = 0;

  int lens[8]   = '{0, 1, 2, 3, 4, 5, 0, 0};
  int quotas[8] = '{0, 5, 2, 2, 1, 1, 0, 0};
  int occ[2][8][8];
  int used[2][8];

  tabuleiro_pecas dut (
    .clk        (clk),
    .reset      (reset),
    .valida     (valida),
    .tipo       (tipo),
    .jogador    (jogador),
    .X1         (X1),
    .Y1         (Y1),
    .direcao    (direcao),
    .orientacao (orientacao),
    .ready      (ready),
    .conflito   (conflito),
    .fim        (fim),
    .completo   (completo),
    .rdJogador  (rdJogador),
    .rdX        (rdX),
    .rdY        (rdY),
    .ocupado    (ocupado)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 8; a++) begin
        used[p][a] = 0;
        for (int b = 0; b < 8; b++) occ[p][a][b] = 0;
      end
    end
  endtask

  function automatic logic [1:0] model_completo();
    logic [1:0] r;
    r = 2'b11;
    for (int p = 0; p < 2; p++)
      for (int t = 1; t <= 5; t++)
        if (used[p][t] != quotas[t]) r[p] = 1'b0;
    return r;
  endfunction

  task automatic check_board(input string tag);
    logic [63:0] obs, exp;
    for (int p = 0; p < 2; p++) begin
      obs = '0;
      exp = '0;
      for (int y = 0; y < 8; y++) begin
        for (int x = 0; x < 8; x++) begin
          @(negedge clk);
          rdJogador = p[0];
          rdX = x[2:0];
          rdY = y[2:0];
          @(posedge clk);
          #1;
          obs[y*8+x] = ocupado;
          exp[y*8+x] = (occ[p][x][y] != 0);
        end
      end
      check($sformatf("%s board p%0d", tag, p), obs, exp);
    end
  endtask

  // Expands the piece from the placement rules and predicts latency/result.
  task automatic predict(input int t, j, x, y, d, o,
                         output int lat, output bit conf,
                         output int cx[5], output int cy[5]);
    int len, s, m, c;
    len  = lens[t];
    s    = o ? -1 : 1;
    conf = 1'b0;
    lat  = 2 * len + 1;
    for (int k = 0; k < len; k++) begin
      m = (d ? y : x) + s * k;
      c = (d ? x : y) + ((t == 3 && k == 1) ? 1 : 0);
      cx[k] = d ? c : m;
      cy[k] = d ? m : c;
    end
    if (len == 0 || used[j][t] >= quotas[t]) begin
      conf = 1'b1;
      lat  = 2;
    end else begin
      for (int k = 0; k < len; k++) begin
        if (!conf && (cx[k] < 0 || cx[k] > 7 || cy[k] < 0 || cy[k] > 7 ||
                      occ[j][(cx[k] < 0 || cx[k] > 7) ? 0 : cx[k]]
                            [(cy[k] < 0 || cy[k] > 7) ? 0 : cy[k]] != 0)) begin
          conf = 1'b1;
          lat  = k + 2;
        end
      end
    end
  endtask

  task automatic drive_req(input int t, j, x, y, d, o);
    tipo       = t[2:0];
    jogador    = j[0];
    X1         = x[2:0];
    Y1         = y[2:0];
    direcao    = d[0];
    orientacao = o[0];
  endtask

  task automatic model_commit(input int t, j, input int cx[5], input int cy[5]);
    for (int k = 0; k < lens[t]; k++) occ[j][cx[k]][cy[k]] = 1;
    used[j][t]++;
  endtask

  task automatic req(input int t, j, x, y, d, o, input string tag);
    int lat_exp, cnt;
    bit conf_exp;
    int cx[5], cy[5];
    predict(t, j, x, y, d, o, lat_exp, conf_exp, cx, cy);
    @(negedge clk);
    drive_req(t, j, x, y, d, o);
    valida = 1'b1;
    @(posedge clk);
    #1;
    valida = 1'b0;
    cnt = 1;
    while (!fim && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, " fim seen"}, fim, 1'b1);
    check({tag, " latency"}, cnt, lat_exp);
    check({tag, " conflito"}, conflito, conf_exp);
    if (!conf_exp) model_commit(t, j, cx, cy);
    @(posedge clk);
    #1;
    check({tag, " fim one cycle"}, fim, 1'b0);
    check({tag, " completo"}, completo, model_completo());
  endtask

  initial begin
    int cnt, nfim;
    int cx[5], cy[5];
    int lat_exp;
    bit conf_exp;

    reset = 1'b0;
    valida = 1'b0;
    drive_req(0, 0, 0, 0, 0, 0);
    rdJogador = 1'b0;
    rdX = 3'd0;
    rdY = 3'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", ready, 1'b1);
    check("reset fim", fim, 1'b0);
    check("reset conflito", conflito, 1'b0);
    check("reset completo", completo, 2'b00);
    check("reset ocupado", ocupado, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    check_board("reset");

    req(5, 0, 2, 3, 0, 0, "pa p0");
    check_board("after pa");
    req(4, 0, 6, 0, 0, 0, "enc off-board");
    req(2, 0, 4, 4, 1, 1, "cru collide");
    check_board("after rejects");

    for (int i = 0; i < 5; i++) req(1, 1, i, 0, 0, 0, $sformatf("sub p1 %0d", i));
    req(1, 1, 5, 0, 0, 0, "sub p1 quota");
    req(2, 1, 0, 1, 0, 0, "cru p1 a");
    req(2, 1, 3, 1, 0, 0, "cru p1 b");
    req(3, 1, 0, 2, 0, 0, "hid p1 a");
    req(3, 1, 4, 2, 0, 0, "hid p1 b");
    req(4, 1, 0, 5, 0, 0, "enc p1");
    check("completo before last", completo, 2'b00);
    req(5, 1, 0, 7, 0, 0, "pa p1");
    check("completo p1 full", completo, 2'b10);
    req(2, 1, 6, 6, 1, 0, "p1 after full");
    req(0, 0, 1, 1, 0, 0, "tipo 0");
    req(6, 0, 1, 1, 0, 0, "tipo 6");
    req(7, 0, 1, 1, 0, 0, "tipo 7");
    check_board("after fleet");

    // Second valida during CHECK must be dropped.
    predict(1, 0, 0, 0, 0, 0, lat_exp, conf_exp, cx, cy);
    @(negedge clk);
    drive_req(1, 0, 0, 0, 0, 0);
    valida = 1'b1;
    @(posedge clk);
    #1;
    cnt = 1;
    check("busy ready", ready, 1'b0);
    @(negedge clk);
    drive_req(5, 0, 0, 6, 0, 0);
    @(posedge clk);
    #1;
    cnt = 2;
    @(negedge clk);
    valida = 1'b0;
    while (!fim && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("ignore latency", cnt, lat_exp);
    check("ignore conflito", conflito, conf_exp);
    model_commit(1, 0, cx, cy);
    nfim = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (fim) nfim++;
    end
    check("ignore extra fim", nfim, 0);
    check_board("after ignore");

    // Reset while the encouracado is being written.
    @(negedge clk);
    drive_req(4, 0, 0, 5, 0, 0);
    valida = 1'b1;
    @(posedge clk);
    #1;
    valida = 1'b0;
    nfim = 0;
    for (int i = 2; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (fim) nfim++;
    end
    check("midreset busy", ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    if (fim) nfim++;
    check("midreset ocupado", ocupado, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    repeat (15) begin
      @(posedge clk);
      #1;
      if (fim) nfim++;
    end
    check("midreset no fim", nfim, 0);
    check("midreset ready", ready, 1'b1);
    check("midreset conflito", conflito, 1'b0);
    check("midreset completo", completo, 2'b00);
    check_board("midreset");

    req(3, 0, 7, 7, 0, 1, "hid cross off");
    req(3, 0, 7, 0, 1, 0, "hid vert off");
    req(3, 0, 0, 7, 1, 1, "hid vert dec");

    for (int i = 0; i < 60; i++) begin
      req($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
          $sformatf("rand %0d", i));
    end
    check_board("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
